// File: rtl/alu_acc_sequencer.sv
// Accumulator command sequencer driving an external 4-bit combinational ALU.
// Results are captured into the accumulator and queued with a zero flag in a 4-entry FIFO.
module alu_acc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic       alu_f0,
  output logic       alu_f1,
  input  logic [3:0] alu_out,
  output logic [3:0] acc,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_zero
);

  localparam int unsigned DW         = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PW         = 2;
  localparam int unsigned CW         = 3;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_XOR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic          zero;
    logic [DW-1:0] data;
  } res_t;

  state_e        state;
  state_e        state_nxt;
  op_e           op_q;
  res_t          mem [FIFO_DEPTH];
  res_t          head_q;
  res_t          push_entry;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] result;
  logic          accept;
  logic          push;
  logic          pop;

  // Gated by rst_n so no command can be accepted while reset is asserted
  assign cmd_ready = rst_n && (state == IDLE) && ena && (count < CW'(FIFO_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == EXEC);
  assign res_valid = (count != CW'(0));
  assign pop       = res_ready && res_valid;
  assign res_data  = head_q.data;
  assign res_zero  = head_q.zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    result          = (op_q == OP_LOAD) ? alu_y : alu_out;
    push_entry.zero = (result == DW'(0));
    push_entry.data = result;
  end

  // Operand/select registers and accumulator; selects drop back to ADD after EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      alu_x  <= '0;
      alu_y  <= '0;
      alu_f0 <= 1'b0;
      alu_f1 <= 1'b0;
      op_q   <= OP_ADD;
    end else if (accept) begin
      alu_x  <= acc;
      alu_y  <= cmd_data;
      op_q   <= op_e'(cmd_op);
      alu_f0 <= (cmd_op == OP_SUB);
      alu_f1 <= (cmd_op == OP_XOR);
    end else if (push) begin
      acc    <= result;
      alu_f0 <= 1'b0;
      alu_f1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers, count and registered head; head only moves on push-into-empty or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && (count == CW'(0))) begin
        head_q <= push_entry;
      end else if (pop) begin
        if (count > CW'(1))  head_q <= mem[rd_ptr + 1'b1];
        else if (push)       head_q <= push_entry;
        else                 head_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Self-checking bench for alu_acc_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_acc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic       alu_f0;
  logic       alu_f1;
  logic [3:0] alu_out;
  logic [3:0] acc;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [4:0] sb[$];
  logic [3:0] m_acc;
  logic [3:0] ysel;

  alu_acc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_f0(alu_f0), .alu_f1(alu_f1), .alu_out(alu_out),
    .acc(acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero)
  );

  // Behavioural model of the downstream combinational ALU
  always_comb begin
    ysel    = alu_f0 ? ~alu_y : alu_y;
    alu_out = alu_f1 ? (alu_x ^ alu_y) : 4'(alu_x + ysel + {3'b000, alu_f0});
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [1:0] op, input logic [3:0] d);
    int n;
    logic [3:0] res;
    logic f0e, f1e;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!cmd_ready) begin
      $display("FAIL send_accept op=%0d data=%0d: cmd_ready=0 after %0d cycles, required 1", op, d, n);
      cmd_valid = 1'b0;
      return;
    end
    n_pass++;
    case (op)
      2'd0:    res = m_acc + d;
      2'd1:    res = m_acc - d;
      2'd2:    res = m_acc ^ d;
      default: res = d;
    endcase
    f0e = (op == 2'd1);
    f1e = (op == 2'd2);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 4'($urandom);
    n_checks++;
    if (cmd_ready !== 1'b0 || alu_x !== m_acc || alu_y !== d || alu_f0 !== f0e || alu_f1 !== f1e)
      $display("FAIL exec_inputs op=%0d: rdy=%b x=%0d y=%0d f0=%b f1=%b, required rdy=0 x=%0d y=%0d f0=%b f1=%b",
               op, cmd_ready, alu_x, alu_y, alu_f0, alu_f1, m_acc, d, f0e, f1e);
    else n_pass++;
    m_acc = res;
    sb.push_back({res == 4'd0, res});
    @(negedge clk);
    n_checks++;
    if (acc !== m_acc || alu_f0 !== 1'b0 || alu_f1 !== 1'b0)
      $display("FAIL acc_update op=%0d: acc=%0d f0=%b f1=%b, required acc=%0d f0=0 f1=0",
               op, acc, alu_f0, alu_f1, m_acc);
    else n_pass++;
  endtask

  task automatic pop();
    int n;
    logic [4:0] exp;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!res_valid || sb.size() == 0) begin
      $display("FAIL pop_valid: res_valid=%b queued=%0d, required both nonzero", res_valid, sb.size());
      return;
    end
    exp = sb.pop_front();
    if ({res_zero, res_data} !== exp)
      $display("FAIL pop_data: zero=%b data=%0d, required zero=%b data=%0d",
               res_zero, res_data, exp[4], exp[3:0]);
    else n_pass++;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 4'd9; res_ready = 1'b0;
    m_acc = 4'd0;
    #12;
    n_checks++;
    if (cmd_ready !== 1'b0 || acc !== 4'd0 || alu_x !== 4'd0 || alu_y !== 4'd0 ||
        alu_f0 !== 1'b0 || alu_f1 !== 1'b0 || res_valid !== 1'b0 || res_data !== 4'd0 || res_zero !== 1'b0)
      $display("FAIL reset_state: rdy=%b acc=%0d x=%0d y=%0d f0=%b f1=%b rv=%b rd=%0d rz=%b, required all 0",
               cmd_ready, acc, alu_x, alu_y, alu_f0, alu_f1, res_valid, res_data, res_zero);
    else n_pass++;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_chain();
    send(2'd3, 4'd5);
    send(2'd0, 4'd3);
    send(2'd1, 4'd2);
    repeat (3) pop();
  endtask

  task automatic test_wrap();
    send(2'd3, 4'd15);
    send(2'd0, 4'd1);
    pop(); pop();
    send(2'd3, 4'd2);
    send(2'd1, 4'd5);
    send(2'd3, 4'd6);
    send(2'd2, 4'hF);
    repeat (4) pop();
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 4; i++) send(2'd3, 4'(i));
    fork
      send(2'd3, 4'd5);
      begin
        repeat (4) begin
          @(negedge clk);
          n_checks++;
          if (cmd_ready !== 1'b0) $display("FAIL full_block: cmd_ready=%b, required 0", cmd_ready);
          else n_pass++;
        end
        pop();
      end
    join
    repeat (4) pop();
  endtask

  task automatic test_back_to_back();
    int n;
    send(2'd3, 4'd7);
    send(2'd0, 4'd1);
    fork
      send(2'd2, 4'd3);
      begin
        n = 0;
        @(negedge clk); #1;
        while (!(cmd_valid && cmd_ready) && n < 50) begin @(negedge clk); #1; n++; end
        pop();
      end
    join
    pop(); pop();
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL simul_count: res_valid=%b after draining, required 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_ena();
    send(2'd3, 4'd9);
    @(negedge clk);
    ena = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'd1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b0 || acc !== 4'd9)
        $display("FAIL ena_block: cmd_ready=%b acc=%0d, required 0 and 9", cmd_ready, acc);
      else n_pass++;
    end
    cmd_valid = 1'b0;
    pop();
    ena = 1'b1;
  endtask

  task automatic test_reset_mid_exec();
    int n;
    send(2'd3, 4'd3);
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'd7;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (alu_x !== 4'd3 || alu_y !== 4'd7)
      $display("FAIL midexec_inputs: x=%0d y=%0d, required 3 and 7", alu_x, alu_y);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (acc !== 4'd0 || alu_x !== 4'd0 || alu_y !== 4'd0 || alu_f0 !== 1'b0 || alu_f1 !== 1'b0 ||
        res_valid !== 1'b0 || res_data !== 4'd0 || res_zero !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL midexec_reset: acc=%0d x=%0d y=%0d f0=%b f1=%b rv=%b rd=%0d rz=%b rdy=%b, required all 0",
               acc, alu_x, alu_y, alu_f0, alu_f1, res_valid, res_data, res_zero, cmd_ready);
    else n_pass++;
    m_acc = 4'd0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || acc !== 4'd0)
      $display("FAIL midexec_discard: res_valid=%b acc=%0d, required 0 and 0", res_valid, acc);
    else n_pass++;
  endtask

  initial begin
    cmd_op = 2'd0; cmd_data = 4'd0;
    test_reset();
    test_basic_chain();
    test_wrap();
    test_fifo_full();
    test_back_to_back();
    test_ena();
    test_reset_mid_exec();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Accumulator-based command sequencer that sits directly upstream of the team's combinational 4-bit ALU (add/sub/xor, selected by F0/F1). It accepts operation commands over a valid/ready handshake and drives the ALU operands and function selects from registers. It captures the ALU result into a 4-bit accumulator, and queues each result, with a zero flag, in a 4-entry output FIFO. The accumulator feeds back as the ALU X operand, so chains of operations run without external operand storage.

## Interface
- FIFO_DEPTH, 4, result FIFO entries; fixed at 4 for this tapeout; implementation need not support other values.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; gates command acceptance only.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op  in  2  operation:
  - 00 = ADD (acc + data)
  - 01 = SUB (acc − data)
  - 10 = XOR (acc ^ data)
  - 11 = LOAD (acc = data)
- cmd_data  in  4  Y operand or load value.
- alu_x  out  4  ALU X operand; registered.
- alu_y  out  4  ALU Y operand; registered.
- alu_f0  out  1  ALU subtract select / carry-in; registered.
- alu_f1  out  1  ALU output select, 0 = sum, 1 = xor; registered.
- alu_out  in  4  combinational ALU result.
- acc  out  4  current accumulator value.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  consumer pops the head on the edge where res_valid && res_ready.
- res_data  out  4  FIFO head result.
- res_zero  out  1  FIFO head result == 0.

## Operation
- State machine with two states:
  - IDLE: waits for a command. cmd_ready = (state==IDLE) && ena && (fifo_count < 4), combinational.
  - EXEC: one cycle. ALU inputs are stable and alu_out is sampled.
- IDLE → EXEC on a handshake. On that edge the block registers:
  - alu_x <= acc, alu_y <= cmd_data, and op.
  - ADD: f0=0, f1=0.
  - SUB: f0=1, f1=0.
  - XOR: f0=0, f1=1.
  - LOAD: f0=0, f1=0; alu_out is ignored for LOAD.
- EXEC → IDLE unconditionally. On that edge:
  - acc <= (op==LOAD) ? alu_y : alu_out.
  - Push {result==0, result} into the FIFO.
- Arithmetic is modulo 16 with no carry or overflow output.
  - SUB is X + ~Y + 1 mod 16.
- FIFO: 4 entries with circular read and write pointers and a 3-bit count.
  - A push cannot overflow, because acceptance required count<4 and pops only free space.
  - A simultaneous push and pop writes and reads both; count is unchanged.
  - A pop when empty is ignored.
- ena low blocks new commands only. An in-flight EXEC completes, and FIFO pops continue.
- cmd_data and cmd_op are not sampled outside the handshake edge.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state = IDLE, acc = 0
  - alu_x = 0, alu_y = 0, alu_f0 = 0, alu_f1 = 0
  - FIFO empty, so res_valid = 0, res_data = 0, res_zero = 0
  - cmd_ready = 0 while rst_n is low.
- Reset mid-operation aborts any EXEC. The result is discarded and not pushed.
- Latency, for a command accepted at edge k:
  - ALU inputs are valid after edge k.
  - acc updates at edge k+1.
  - res_valid rises after edge k+1 if the FIFO was empty.
- Throughput: one command per 2 cycles; cmd_ready is low during EXEC.
- res_data and res_zero come from the FIFO head, registered. They change only on push into an empty FIFO or on pop.
- A command presented with cmd_valid in EXEC is held until the following IDLE cycle.

## Test plan
- LOAD 5, then ADD 3, then SUB 2:
  - acc is 5, 8, 6 in turn.
  - FIFO pops 5, 8, 6, all with res_zero = 0.
  - alu_f0 = 1 only during the SUB EXEC.
- Wrap-around:
  - LOAD 15 then ADD 1 → acc = 0, res_zero = 1.
  - LOAD 2 then SUB 5 → acc = 13.
- LOAD 6 then XOR 0xF → acc = 9, alu_f1 = 1 during EXEC.
- FIFO full:
  - Hold res_ready = 0 and issue 4 LOADs (1, 2, 3, 4). cmd_ready stays low with a 5th command pending.
  - Pop once. The 5th command is accepted in the next IDLE cycle.
  - Pop order is 1, 2, 3, 4, then the 5th.
- Simultaneous push and pop with FIFO count 2 → count stays 2 and order is preserved.
- Reset mid-EXEC during ADD 7 from acc = 3:
  - All outputs go to reset values immediately; acc = 0 and res_valid = 0.
  - No result is pushed after rst_n releases.
